// File: rtl/int2flt_pkg.sv
// Shared types and constants for the int-to-float conversion engine.
// Holds the FSM state enum, the float field widths and the rounding/packing helper.
package int2flt_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned EXP_W    = 5;
   localparam int unsigned MANT_W   = 10;
   localparam int unsigned EXP_BIAS = 15;
   localparam int unsigned LZ_W     = 4;

   // Bit positions within a normalised magnitude (bit WORD_W-1 is the hidden one).
   localparam int unsigned MANT_LSB  = WORD_W - 1 - MANT_W;
   localparam int unsigned GUARD_BIT = MANT_LSB - 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_HI,
      S_RD_LO,
      S_CAP,
      S_NORM,
      S_ROUND,
      S_WR_HI,
      S_WR_LO,
      S_DONE
   } state_t;

   // Round-to-nearest-even packing of a normalised, nonzero magnitude.
   // A mantissa carry leaves the low MANT_W bits at zero, so only the exponent needs fixing.
   function automatic logic [WORD_W-1:0] pack_float(
      input logic              sign,
      input logic [WORD_W-1:0] norm,
      input logic [LZ_W-1:0]   lz
   );
      logic [MANT_W:0]  mant;
      logic [EXP_W-1:0] expo;
      logic             guard;
      logic             sticky;
      logic             inc;
      expo   = EXP_W'(EXP_BIAS + 15) - EXP_W'(lz);
      guard  = norm[GUARD_BIT];
      sticky = |norm[GUARD_BIT-1:0];
      inc    = guard & (sticky | norm[MANT_LSB]);
      mant   = {1'b0, norm[WORD_W-2:MANT_LSB]} + {{MANT_W{1'b0}}, inc};
      if (mant[MANT_W]) begin
         expo = expo + 1'b1;
      end
      return {sign, expo, mant[MANT_W-1:0]};
   endfunction

endpackage

// File: rtl/int2flt_engine_lzc16.sv
// lzc16: combinational 16-bit leading-zero counter used by the single-cycle normaliser.
// An all-zero input reports 15; the engine never presents zero here.
module lzc16
   import int2flt_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [LZ_W-1:0]   o_lz
);

   // Ascending scan: the highest set bit is visited last and wins.
   always_comb begin
      o_lz = LZ_W'(WORD_W - 1);
      for (int unsigned i = 0; i < WORD_W; i++) begin
         if (i_word[i]) begin
            o_lz = LZ_W'(WORD_W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/int2flt_engine.sv
// Sequential int16 -> float16 converter on a byte-wide data-memory port.
// Define INT2FLT_FAST_NORM_EN for a single-cycle normaliser (lzc16 + barrel shift).
module int2flt_engine
   import int2flt_pkg::*;
#(
   parameter int unsigned NUM_WORDS = 15,
   parameter int unsigned SRC_BASE  = 0,
   parameter int unsigned DST_BASE  = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] dm_rdata,
   output logic [7:0] dm_addr,
   output logic       dm_rd,
   output logic       dm_wr,
   output logic [7:0] dm_wdata,
   output logic       busy,
   output logic       done
);

   if (NUM_WORDS == 0 || NUM_WORDS > 63) begin : g_bad_num_words
      $error("int2flt_engine: NUM_WORDS must be within 1..63");
   end

   state_t            r_state;
   state_t            w_next;
   logic [5:0]        r_idx;
   logic [7:0]        r_hi;
   logic              r_sign;
   logic [WORD_W-1:0] r_mag;
   logic [LZ_W-1:0]   r_lz;
   logic [WORD_W-1:0] r_result;

   logic [WORD_W-1:0] w_operand;
   logic [WORD_W-1:0] w_mag;
   logic [5:0]        w_idx_inc;
   logic [7:0]        w_src_addr;
   logic [7:0]        w_dst_addr;

   assign w_operand  = {r_hi, dm_rdata};
   assign w_mag      = w_operand[WORD_W-1] ? (~w_operand + 1'b1) : w_operand;
   assign w_idx_inc  = r_idx + 6'd1;
   assign w_src_addr = 8'(SRC_BASE) + {1'b0, r_idx, 1'b0};
   assign w_dst_addr = 8'(DST_BASE) + {1'b0, r_idx, 1'b0};

`ifdef INT2FLT_FAST_NORM_EN
   logic [LZ_W-1:0] w_lz;

   lzc16 u_lzc16 (
      .i_word (r_mag),
      .o_lz   (w_lz)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      dm_addr  = '0;
      dm_rd    = 1'b0;
      dm_wr    = 1'b0;
      dm_wdata = '0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_RD_HI;
         end
         S_RD_HI: begin
            busy    = 1'b1;
            dm_rd   = 1'b1;
            dm_addr = w_src_addr;
            w_next  = S_RD_LO;
         end
         S_RD_LO: begin
            busy    = 1'b1;
            dm_rd   = 1'b1;
            dm_addr = w_src_addr + 8'd1;
            w_next  = S_CAP;
         end
         S_CAP: begin
            busy   = 1'b1;
            w_next = (w_operand == '0) ? S_ROUND : S_NORM;
         end
         S_NORM: begin
            busy = 1'b1;
`ifdef INT2FLT_FAST_NORM_EN
            w_next = S_ROUND;
`else
            if (r_mag[WORD_W-1]) w_next = S_ROUND;
`endif
         end
         S_ROUND: begin
            busy   = 1'b1;
            w_next = S_WR_HI;
         end
         S_WR_HI: begin
            busy     = 1'b1;
            dm_wr    = 1'b1;
            dm_addr  = w_dst_addr;
            dm_wdata = r_result[15:8];
            w_next   = S_WR_LO;
         end
         S_WR_LO: begin
            busy     = 1'b1;
            dm_wr    = 1'b1;
            dm_addr  = w_dst_addr + 8'd1;
            dm_wdata = r_result[7:0];
            w_next   = (w_idx_inc == 6'(NUM_WORDS)) ? S_DONE : S_RD_HI;
         end
         S_DONE: begin
            done = 1'b1;
            if (start) w_next = S_RD_HI;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx    <= '0;
         r_hi     <= '0;
         r_sign   <= 1'b0;
         r_mag    <= '0;
         r_lz     <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) r_idx <= '0;
            end
            S_RD_LO: r_hi <= dm_rdata;
            S_CAP: begin
               r_sign <= w_operand[WORD_W-1];
               r_mag  <= w_mag;
               r_lz   <= '0;
            end
            S_NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
               r_mag <= r_mag << w_lz;
               r_lz  <= w_lz;
`else
               if (!r_mag[WORD_W-1]) begin
                  r_mag <= {r_mag[WORD_W-2:0], 1'b0};
                  r_lz  <= r_lz + 1'b1;
               end
`endif
            end
            S_ROUND: r_result <= (r_mag == '0) ? '0 : pack_float(r_sign, r_mag, r_lz);
            S_WR_LO: r_idx <= w_idx_inc;
            default: ;
         endcase
      end
   end

endmodule
